imm_gen_stage: RTL and testbench

//  Pipelined, parametrised immediate-generation stage between fetch and execute.

---
 rtl/imm_gen_stage.sv | 168 ++++++++++++++++
 tb/tb_imm_gen_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes RISC-V immediates and the
// PC-relative target, and registers them behind a 2-entry valid/ready skid buffer.
module imm_gen_stage #(
  parameter int XLEN     = 32,
  parameter bit EN_ZICSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
  } entry_t;

  state_t state_reg, state_next;
  entry_t out_reg, skid_reg, dec_entry;

  logic signed [31:0] imm32;
  logic [XLEN-1:0]    imm_dec;
  logic [2:0]         fmt_dec;
  logic               has_target;
  logic               accept_fire, release_fire;
  logic               load_out_from_in, load_out_from_skid, load_skid_from_in;

  // All formats are first built as a signed 32-bit value, then sign-extended to XLEN.
  always_comb begin
    imm32      = '0;
    fmt_dec    = FMT_NONE;
    has_target = 1'b0;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        fmt_dec = FMT_I;
      end
      7'b0100011: begin
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        fmt_dec = FMT_S;
      end
      7'b1100011: begin
        imm32      = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
        fmt_dec    = FMT_B;
        has_target = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        imm32      = {in_instr[31:12], 12'b0};
        fmt_dec    = FMT_U;
        has_target = in_instr[5] == 1'b0; // AUIPC only
      end
      7'b1101111: begin
        imm32      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
        fmt_dec    = FMT_J;
        has_target = 1'b1;
      end
      7'b1110011: begin
        if (EN_ZICSR && in_instr[14]) begin
          imm32   = {27'b0, in_instr[19:15]};
          fmt_dec = FMT_Z;
        end
      end
      default: ;
    endcase
  end

  assign imm_dec          = XLEN'(imm32);
  assign dec_entry.instr  = in_instr;
  assign dec_entry.pc     = in_pc;
  assign dec_entry.imm    = imm_dec;
  assign dec_entry.fmt    = fmt_dec;
  assign dec_entry.target = has_target ? in_pc + imm_dec : '0;

  // Handshake flags come straight from the state register, never from out_ready.
  assign out_valid    = (state_reg != ST_EMPTY);
  assign in_ready     = (state_reg != ST_TWO);
  assign accept_fire  = in_valid & in_ready;
  assign release_fire = out_valid & out_ready;

  always_comb begin
    state_next         = state_reg;
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid_from_in  = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (accept_fire) begin
          state_next       = ST_ONE;
          load_out_from_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept_fire && release_fire) begin
          load_out_from_in = 1'b1;
        end else if (accept_fire) begin
          state_next        = ST_TWO;
          load_skid_from_in = 1'b1;
        end else if (release_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (release_fire) begin
          state_next         = ST_ONE;
          load_out_from_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    // A flush discards everything, including an instruction accepted this cycle.
    if (flush) begin
      state_next         = ST_EMPTY;
      load_out_from_in   = 1'b0;
      load_out_from_skid = 1'b0;
      load_skid_from_in  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      out_reg   <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load_out_from_in) begin
        out_reg <= dec_entry;
      end else if (load_out_from_skid) begin
        out_reg <= skid_reg;
      end
      if (load_skid_from_in) begin
        skid_reg <= dec_entry;
      end
    end
  end

  assign out_instr  = out_reg.instr;
  assign out_pc     = out_reg.pc;
  assign out_imm    = out_reg.imm;
  assign out_fmt    = out_reg.fmt;
  assign out_target = out_reg.target;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Drives a 32-bit/zicsr and a 64-bit/no-zicsr instance with shared handshake
// stimulus and checks both against an arithmetic decode model and a FIFO scoreboard.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] pc;

  logic        r32, v32, r64, v64;
  logic [31:0] instr32, pc32, imm32, tgt32, instr64;
  logic [63:0] pc64, imm64, tgt64;
  logic [2:0]  fmt32, fmt64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm32, imm64, tgt32, tgt64;
    logic [2:0]  fmt32, fmt64;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .EN_ZICSR(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_pc(pc[31:0]),
    .out_valid(v32), .out_ready(out_ready), .out_instr(instr32), .out_pc(pc32),
    .out_imm(imm32), .out_fmt(fmt32), .out_target(tgt32)
  );

  imm_gen_stage #(.XLEN(64), .EN_ZICSR(1'b0)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_pc(pc),
    .out_valid(v64), .out_ready(out_ready), .out_instr(instr64), .out_pc(pc64),
    .out_imm(imm64), .out_fmt(fmt64), .out_target(tgt64)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Immediate as a signed integer from field weights, then reduced modulo 2^xlen.
  function automatic void ref_dec(input logic [31:0] ins, input logic [63:0] pcv,
                                  input bit zicsr, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic [63:0] tgt);
    longint v = 0;
    bit     t = 0;
    logic [63:0] mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    fmt = 3'd0;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
        fmt = 3'd1;
      end
      7'b0100011: begin
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v -= 4096;
        fmt = 3'd2;
      end
      7'b1100011: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
        fmt = 3'd3;
        t = 1;
      end
      7'b0110111, 7'b0010111: begin
        v = longint'(ins[31:12]) * 4096;
        if (v >= (longint'(1) << 31)) v -= (longint'(1) << 32);
        fmt = 3'd4;
        t = (ins[6:0] == 7'b0010111);
      end
      7'b1101111: begin
        v = longint'(ins[31]) * (longint'(1) << 20) + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= (longint'(1) << 20)) v -= (longint'(1) << 21);
        fmt = 3'd5;
        t = 1;
      end
      7'b1110011: begin
        if (zicsr && ins[14]) begin
          v = longint'(ins[19:15]);
          fmt = 3'd6;
        end
      end
      default: ;
    endcase
    imm = 64'(v) & mask;
    tgt = t ? ((pcv + 64'(v)) & mask) : 64'h0;
  endfunction

  task automatic compare_all();
    exp_t e;
    check_eq("valid32", v32, q.size() > 0);
    check_eq("ready32", r32, q.size() < 2);
    check_eq("valid64", v64, q.size() > 0);
    check_eq("ready64", r64, q.size() < 2);
    if (q.size() > 0) begin
      e = q[0];
      check_eq("instr32", instr32, e.instr);
      check_eq("pc32", pc32, e.pc[31:0]);
      check_eq("imm32", imm32, e.imm32);
      check_eq("fmt32", fmt32, e.fmt32);
      check_eq("tgt32", tgt32, e.tgt32);
      check_eq("instr64", instr64, e.instr);
      check_eq("pc64", pc64, e.pc);
      check_eq("imm64", imm64, e.imm64);
      check_eq("fmt64", fmt64, e.fmt64);
      check_eq("tgt64", tgt64, e.tgt64);
    end
  endtask

  // One clock: drive inputs, advance the scoreboard, then compare just after the edge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pcv,
                      input bit ordy, input bit fl, input bit rs);
    exp_t e;
    bit   acc, rel;
    rst = rs; flush = fl; in_valid = v; in_instr = ins; pc = pcv; out_ready = ordy;
    acc = v && (q.size() < 2);
    rel = ordy && (q.size() > 0);
    if (rs || fl) begin
      q.delete();
    end else begin
      if (rel) begin
        e = q.pop_front();
        $display("tx instr=%08h pc=%016h imm32=%08h imm64=%016h fmt=%0d/%0d",
                 e.instr, e.pc, e.imm32[31:0], e.imm64, e.fmt32, e.fmt64);
      end
      if (acc) begin
        e.instr = ins;
        e.pc    = pcv;
        ref_dec(ins, pcv, 1'b1, 32, e.imm32, e.fmt32, e.tgt32);
        ref_dec(ins, pcv, 1'b0, 64, e.imm64, e.fmt64, e.tgt64);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
  endtask

  bit [6:0] ops[11] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                        7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011,
                        7'b0001111};

  initial begin
    logic [31:0] ins;
    logic [63:0] pcv;

    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_imm32", imm32, 32'h0);
    check_eq("rst_tgt64", tgt64, 64'h0);
    check_eq("rst_instr32", instr32, 32'h0);
    check_eq("rst_fmt64", fmt64, 3'd0);

    step(1'b1, 32'hFFF0_0093, 64'h40, 1'b1, 1'b0, 1'b0);
    check_eq("addi_imm", imm32, 32'hFFFF_FFFF);
    check_eq("addi_fmt", fmt32, 3'd1);
    check_eq("addi_tgt", tgt32, 32'h0);

    step(1'b1, 32'hFE00_0EE3, 64'h100, 1'b1, 1'b0, 1'b0);
    check_eq("beq_imm", imm32, 32'hFFFF_FFFC);
    check_eq("beq_fmt", fmt32, 3'd3);
    check_eq("beq_tgt", tgt32, 32'h0000_00FC);

    step(1'b1, 32'h8000_00B7, 64'h200, 1'b1, 1'b0, 1'b0);
    check_eq("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
    check_eq("lui64_fmt", fmt64, 3'd4);
    check_eq("lui64_tgt", tgt64, 64'h0);
    step(1'b1, 32'h1234_50B7, 64'h204, 1'b1, 1'b0, 1'b0);
    check_eq("lui64_pos", imm64, 64'h0000_0000_1234_5000);

    step(1'b1, 32'h340F_D0F3, 64'h208, 1'b1, 1'b0, 1'b0);
    check_eq("zimm_imm", imm32, 32'h1F);
    check_eq("zimm_fmt", fmt32, 3'd6);
    check_eq("nozicsr_imm", imm64, 64'h0);
    check_eq("nozicsr_fmt", fmt64, 3'd0);
    idle(2);

    // Backpressure: three back-to-back instructions with the sink stalled.
    step(1'b1, 32'h0010_0113, 64'h300, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0193, 64'h304, 1'b0, 1'b0, 1'b0);
    check_eq("bp_ready_low", r32, 1'b0);
    step(1'b1, 32'h0030_0213, 64'h308, 1'b0, 1'b0, 1'b0);
    check_eq("bp_hold_instr", instr32, 32'h0010_0113);
    step(1'b1, 32'h0030_0213, 64'h308, 1'b1, 1'b0, 1'b0);
    check_eq("bp_second", instr32, 32'h0020_0193);
    step(1'b1, 32'h0030_0213, 64'h308, 1'b1, 1'b0, 1'b0);
    check_eq("bp_third", instr32, 32'h0030_0213);
    idle(2);

    // Flush with both entries held and a same-cycle input.
    step(1'b1, 32'h0040_0293, 64'h400, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0050_0313, 64'h404, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0060_0393, 64'h408, 1'b0, 1'b1, 1'b0);
    check_eq("flush_valid", v32, 1'b0);
    check_eq("flush_ready", r32, 1'b1);
    idle(2);

    // Reset while two entries are held.
    step(1'b1, 32'h0070_0413, 64'h500, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0080_0493, 64'h504, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0090_0513, 64'h508, 1'b1, 1'b0, 1'b1);
    check_eq("rst2_valid", v64, 1'b0);
    check_eq("rst2_ready", r64, 1'b1);
    check_eq("rst2_imm", imm64, 64'h0);
    idle(1);

    for (int i = 0; i < 800; i++) begin
      ins = $urandom();
      if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 10)];
      pcv = {$urandom(), $urandom()};
      step($urandom_range(0, 9) < 7, ins, pcv, $urandom_range(0, 9) < 6,
           $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
